// File: rtl/fpu_seq_mantissa_mul.sv
// Sequential shift-add mantissa multiplier retiring BITS_PER_CYCLE multiplier bits per cycle,
// with optional early exit and valid/ready handshakes on operands and product.
module fpu_seq_mantissa_mul #(
  parameter int WIDTH          = 11,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_EXIT     = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               outValid,
  input  logic               outReady,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int K     = BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int ITER  = (WIDTH + K - 1) / K;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMP,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [PW-1:0]    a_reg;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] step;

  logic [PW-1:0]    digit;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] b_rest;
  logic             exit_comp;
  logic             accept;

  // One radix-2^K digit per cycle; the top digit picks up zeros shifted in from above.
  always_comb begin
    digit     = PW'(b_reg[K-1:0]);
    partial   = a_reg * digit;
    acc_sum   = acc + partial;
    b_rest    = b_reg >> K;
    exit_comp = (step == LAST_STEP) || ((EARLY_EXIT != 0) && (b_rest == '0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    inReady    = 1'b0;
    busy       = 1'b0;
    outValid   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          accept     = 1'b1;
          state_next = COMP;
        end
      end
      COMP: begin
        busy = 1'b1;
        if (exit_comp) begin
          state_next = DONE;
        end
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
    end else if (accept) begin
      a_reg <= PW'(a);
      b_reg <= b;
      acc   <= '0;
      step  <= '0;
    end else if (state == COMP) begin
      acc   <= acc_sum;
      a_reg <= a_reg << K;
      b_reg <= b_rest;
      step  <= step + CNT_W'(1);
      // product only moves on a COMP exit, so it survives the output handshake.
      if (exit_comp) begin
        product <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_fpu_seq_mantissa_mul.sv
// Scoreboard bench: several multiplier configurations run in parallel against an
// arithmetic reference (a*b and a digit-count latency model).
module tb_fpu_seq_mantissa_mul;

  localparam int NCFG   = 7;
  localparam int NOPS   = 40;
  localparam int RST_OP = 8;

  typedef struct {
    longint unsigned prod;
    int              lat;
    int              acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  function automatic int cfg_w(input int g);
    case (g)
      4, 5:    return 24;
      default: return 11;
    endcase
  endfunction

  function automatic int cfg_k(input int g);
    case (g)
      1:       return 2;
      2:       return 4;
      4:       return 3;
      5:       return 5;
      6:       return 11;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_e(input int g);
    return (g == 3 || g == 5 || g == 6) ? 1 : 0;
  endfunction

  // Cycles spent computing: every digit, or only up to the last non-zero digit of b.
  function automatic int model_lat(input int w, input int k, input int e, input longint unsigned bv);
    int iter;
    int n;
    iter = (w + k - 1) / k;
    if (e == 0) return iter;
    n = 1;
    while (n < iter && (bv >> (k * n)) != 0) n++;
    return n;
  endfunction

  task automatic check(input string name, input int inst, input longint unsigned act,
                       input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d actual=0x%0h expected=0x%0h", name, inst, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_inst
    localparam int W = cfg_w(g);
    localparam int K = cfg_k(g);
    localparam int E = cfg_e(g);

    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    exp_t           q[$];

    fpu_seq_mantissa_mul #(
      .WIDTH(W),
      .BITS_PER_CYCLE(K),
      .EARLY_EXIT(E)
    ) dut (
      .clock(clk),
      .reset(rst_n),
      .inValid(in_valid),
      .inReady(in_ready),
      .a(a),
      .b(b),
      .outValid(out_valid),
      .outReady(out_ready),
      .product(product),
      .busy(busy)
    );

    function automatic logic [W-1:0] rnd_a();
      return W'($urandom);
    endfunction

    function automatic logic [W-1:0] rnd_b();
      logic [W-1:0] v;
      v = W'($urandom);
      if ($urandom_range(0, 2) == 0) v = v >> $urandom_range(1, W);
      return v;
    endfunction

    // Operands keep changing while the block is not ready; only the pair present at accept counts.
    task automatic wait_accept(input bit directed, output bit ok);
      int waited;
      waited = 0;
      ok     = 1'b0;
      forever begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
        if (waited == 400) break;
        waited++;
        @(posedge clk);
        #1;
        if (!directed) begin
          a = rnd_a();
          b = rnd_b();
        end
      end
    endtask

    task automatic push_expected();
      exp_t e;
      e.prod    = 64'(a) * 64'(b);
      e.lat     = model_lat(W, K, E, 64'(b));
      e.acc_cyc = cyc + 1;
      q.push_back(e);
    endtask

    initial begin : drive
      logic [W-1:0] aa;
      logic [W-1:0] bb;
      logic [W-1:0] ones;
      logic [W-1:0] hi;
      bit           directed;
      bit           ok;
      int           waited;
      ones     = '1;
      hi       = '0;
      hi[W-1]  = 1'b1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_product", g, 64'(product), 64'd0);
      check("reset_out_valid", g, 64'(out_valid), 64'd0);
      check("reset_in_ready", g, 64'(in_ready), 64'd1);
      check("reset_busy", g, 64'(busy), 64'd0);
      #1 rst_n = 1'b1;

      for (int op = 0; op < NOPS; op++) begin
        directed = 1'b1;
        case (op)
          0:          begin aa = hi;            bb = hi;     end
          1:          begin aa = ones;          bb = ones;   end
          2:          begin aa = W'(32'h5A5);   bb = W'(1);  end
          3:          begin aa = W'(32'h5A5);   bb = '0;     end
          4:          begin aa = ones;          bb = hi;     end
          RST_OP + 1: begin aa = hi;            bb = hi;     end
          default:    begin directed = 1'b0; aa = rnd_a(); bb = rnd_b(); end
        endcase

        if (op == RST_OP) begin
          @(posedge clk);
          #1;
          a = ones;
          b = ones;
          in_valid = 1'b1;
          wait_accept(1'b1, ok);
          if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout inst=%0d actual=no_accept expected=accept", g);
            break;
          end
          push_expected();
          @(posedge clk);
          #1 in_valid = 1'b0;
          repeat (3) @(posedge clk);
          #1 rst_n = 1'b0;
          #1;
          check("midop_reset_product", g, 64'(product), 64'd0);
          check("midop_reset_out_valid", g, 64'(out_valid), 64'd0);
          check("midop_reset_in_ready", g, 64'(in_ready), 64'd1);
          check("midop_reset_busy", g, 64'(busy), 64'd0);
          q.delete();
          @(negedge clk);
          @(negedge clk);
          #1 rst_n = 1'b1;
        end else begin
          @(posedge clk);
          #1;
          a = aa;
          b = bb;
          in_valid = 1'b1;
          wait_accept(directed, ok);
          if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout inst=%0d actual=no_accept expected=accept", g);
            break;
          end
          push_expected();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
        end
      end

      @(posedge clk);
      #1 in_valid = 1'b0;
      waited = 0;
      while ((q.size() != 0 || out_valid) && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 2000) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout inst=%0d actual=%0d_pending expected=0_pending", g, q.size());
      end
      done_cnt++;
    end

    initial begin : backpressure
      int hold_cnt;
      hold_cnt  = 0;
      out_ready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
          out_ready = 1'b0;
          hold_cnt--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 7) == 0) hold_cnt = 6;
        end
      end
    end

    initial begin : monitor
      bit             seen;
      bit             prev_hold;
      logic [2*W-1:0] held;
      exp_t           e;
      seen      = 1'b0;
      prev_hold = 1'b0;
      held      = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          seen      = 1'b0;
          prev_hold = 1'b0;
        end else begin
          if (prev_hold) begin
            check("hold_out_valid", g, 64'(out_valid), 64'd1);
            check("hold_product", g, 64'(product), 64'(held));
          end
          if (out_valid) begin
            check("done_in_ready", g, 64'(in_ready), 64'd0);
            check("done_busy", g, 64'(busy), 64'd0);
          end
          if (out_valid && !seen) begin
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_output inst=%0d actual=0x%0h expected=no_output", g, product);
            end else begin
              e = q.pop_front();
              check("product", g, 64'(product), e.prod);
              check("latency", g, 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
            seen = 1'b1;
            held = product;
          end
          if (out_valid && out_ready) seen = 1'b0;
          prev_hold = out_valid && !out_ready;
        end
      end
    end
  end

  initial begin : main_ctl
    int waited;
    waited = 0;
    while (done_cnt < NCFG && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    if (done_cnt < NCFG) begin
      tests++;
      fails++;
      $display("FAIL global_timeout actual=%0d_done expected=%0d_done", done_cnt, NCFG);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
